// File: rtl/accum_drain.sv
// rtl/accum_drain.sv - drains a region of one accumulator column through a 2-entry output FIFO
module accum_drain #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_ROWS_NUM   = 128,
  parameter int MAX_OUT_COLS   = 128,
  parameter int SYS_ARR_COLS   = 16,
  localparam int NUM_ACCUM_ROWS = MAX_ROWS_NUM * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int AW             = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [AW-1:0]                base_addr,
  input  logic [AW:0]                  num_rows,
  input  logic                         relu_en,
  input  logic                         clear_after,
  output logic                         busy,
  output logic                         done,
  output logic                         acc_rd_en,
  output logic [AW-1:0]                acc_rd_address,
  input  logic signed [DATA_WIDTH-1:0] acc_rd_data,
  output logic                         acc_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_CLEAR,
    S_FIN
  } state_t;

  state_t                       state;
  logic [AW-1:0]                rd_addr;
  logic [AW:0]                  remaining;
  logic                         relu_q;
  logic                         clear_q;

  // one read may be outstanding between acc_rd_en and the FIFO write
  logic                         inflight;
  logic                         inflight_last;

  logic signed [DATA_WIDTH-1:0] fifo_data [2];
  logic                         fifo_last [2];
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic [1:0]                   fifo_count;

  logic                         pop;
  logic                         push;
  logic                         issue;
  logic [1:0]                   occupancy;
  logic [AW-1:0]                next_addr;
  logic signed [DATA_WIDTH-1:0] push_word;

  // Read issue, FIFO handshake and output decode. The head being popped this
  // cycle is credited so a read can be issued every cycle while out_ready
  // stays high; the worst case (ready dropping next cycle) still fits 2 entries.
  always_comb begin
    out_valid  = (fifo_count != 2'd0);
    pop        = out_valid & out_ready;
    push       = inflight;
    occupancy  = fifo_count + {1'b0, inflight} - {1'b0, pop};
    issue      = (state == S_READ) && (occupancy < 2'd2);
    next_addr  = (rd_addr == AW'(NUM_ACCUM_ROWS - 1)) ? '0 : rd_addr + AW'(1);
    push_word  = (relu_q && acc_rd_data[DATA_WIDTH-1]) ? '0 : acc_rd_data;
    acc_rd_en      = issue;
    acc_rd_address = rd_addr;
    acc_clear      = (state == S_CLEAR);
    done           = (state == S_FIN);
    busy           = (state != S_IDLE);
    out_data       = out_valid ? fifo_data[rd_ptr] : '0;
    out_last       = out_valid ? fifo_last[rd_ptr] : 1'b0;
  end

  // Control FSM: config capture, address walk and end-of-region sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rd_addr       <= '0;
      remaining     <= '0;
      relu_q        <= 1'b0;
      clear_q       <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == (AW+1)'(1));
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_addr   <= base_addr;
            remaining <= num_rows;
            relu_q    <= relu_en;
            clear_q   <= clear_after;
            state     <= (num_rows == '0) ? S_FIN : S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            rd_addr   <= next_addr;
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight) begin
            state <= clear_q ? S_CLEAR : S_FIN;
          end
        end
        S_CLEAR: state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry output FIFO; push and pop may happen in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_word;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_accum_drain.sv
// tb/tb_accum_drain.sv - directed-vector bench for accum_drain
module tb_accum_drain;

  localparam int DW = 16;
  localparam int N  = 128 * (128 / 16);
  localparam int AW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [AW:0]          num_rows;
  logic                 relu_en;
  logic                 clear_after;
  logic                 busy;
  logic                 done;
  logic                 acc_rd_en;
  logic [AW-1:0]        acc_rd_address;
  logic signed [DW-1:0] acc_rd_data;
  logic                 acc_clear;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;

  accum_drain dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_rows       (num_rows),
    .relu_en        (relu_en),
    .clear_after    (clear_after),
    .busy           (busy),
    .done           (done),
    .acc_rd_en      (acc_rd_en),
    .acc_rd_address (acc_rd_address),
    .acc_rd_data    (acc_rd_data),
    .acc_clear      (acc_clear),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  // accumulator column: data valid the cycle after acc_rd_en
  logic signed [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= mem[acc_rd_address];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int data_q[$];
  int last_q[$];
  int addr_q[$];
  int first_valid, last_pop, clear_cyc, clear_cnt, done_cyc, done_cnt;
  int valid_cnt, overlap, stab_err, busy0, busy_after;
  bit finished;

  task automatic run(input int base, input int nrows, input bit relu, input bit clr,
                     input int mode, input bit extra);
    bit stalled_prev;
    int prev_data, prev_last;
    data_q.delete(); last_q.delete(); addr_q.delete();
    first_valid = -1; last_pop = -1; clear_cyc = -1; clear_cnt = 0;
    done_cyc = -1; done_cnt = 0; valid_cnt = 0; overlap = 0; stab_err = 0;
    busy0 = -1; busy_after = -1; finished = 0; stalled_prev = 0;
    prev_data = 0; prev_last = 0;
    @(negedge clk);
    start = 1; base_addr = AW'(base); num_rows = (AW+1)'(nrows);
    relu_en = relu; clear_after = clr; out_ready = 1;
    @(negedge clk);
    relu_en = ~relu; clear_after = ~clr; base_addr = '0; num_rows = '0;
    for (int i = 0; i < 150 && !finished; i++) begin
      if (extra && i == 1) begin
        start = 1; base_addr = AW'(77); num_rows = (AW+1)'(1);
      end else begin
        start = 0;
      end
      out_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      #1;
      if (acc_rd_en) addr_q.push_back(int'(acc_rd_address));
      if (acc_rd_en && acc_clear) overlap++;
      if (acc_clear) begin clear_cnt++; clear_cyc = i; end
      if (done) begin done_cnt++; done_cyc = i; end
      if (out_valid && first_valid < 0) first_valid = i;
      if (out_valid) valid_cnt++;
      if (stalled_prev && (!out_valid || int'(out_data) != prev_data || int'(out_last) != prev_last))
        stab_err++;
      stalled_prev = out_valid && !out_ready;
      prev_data = int'(out_data);
      prev_last = int'(out_last);
      if (out_valid && out_ready) begin
        data_q.push_back(int'(out_data));
        last_q.push_back(int'(out_last));
        last_pop = i;
      end
      if (i == 0) busy0 = int'(busy);
      if (done_cnt > 0 && i == done_cyc + 1) begin
        busy_after = int'(busy);
        finished = 1;
      end
      @(negedge clk);
    end
    start = 0;
    if (!finished) check("timeout", 0, 1);
  endtask

  task automatic check_words(input string tag, input int exp[$]);
    int last_idx, last_n;
    check({tag, "_count"}, data_q.size(), exp.size());
    for (int k = 0; k < exp.size() && k < data_q.size(); k++)
      check($sformatf("%s_word%0d", tag, k), data_q[k], exp[k]);
    last_idx = -1; last_n = 0;
    foreach (last_q[k]) if (last_q[k] != 0) begin last_idx = k; last_n++; end
    check({tag, "_last_n"}, last_n, 1);
    check({tag, "_last_idx"}, last_idx, exp.size() - 1);
  endtask

  int pops, bad;

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[0] = 5; mem[1] = -3; mem[2] = 7; mem[3] = 2;
    mem[N-2] = 100; mem[N-1] = -200;
    mem[10] = 11; mem[11] = -12; mem[12] = 13; mem[13] = -14;
    mem[14] = 15; mem[15] = -16; mem[16] = 17; mem[17] = -18;
    mem[30] = 1; mem[31] = 2; mem[32] = 3;
    mem[20] = 21; mem[21] = -22; mem[22] = 23; mem[23] = 24; mem[24] = -25; mem[25] = 26;

    rst_n = 0; start = 0; base_addr = '0; num_rows = '0;
    relu_en = 0; clear_after = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(acc_rd_en), 0);
    check("rst_clear", int'(acc_clear), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_addr", int'(acc_rd_address), 0);
    rst_n = 1;

    // plain drain with a stray start while busy
    run(0, 4, 0, 0, 0, 1);
    check_words("plain", '{5, -3, 7, 2});
    check("plain_addr_n", addr_q.size(), 4);
    check("plain_first_valid", first_valid, 2);
    check("plain_done_gap", done_cyc - last_pop, 2);
    check("plain_done_n", done_cnt, 1);
    check("plain_clear_n", clear_cnt, 0);
    check("plain_busy0", busy0, 1);
    check("plain_busy_after", busy_after, 0);

    run(0, 4, 1, 0, 0, 1);
    check_words("relu", '{5, 0, 7, 2});

    run(N - 2, 4, 0, 0, 0, 1);
    check("wrap_addr_n", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      check("wrap_addr0", addr_q[0], N - 2);
      check("wrap_addr1", addr_q[1], N - 1);
      check("wrap_addr2", addr_q[2], 0);
      check("wrap_addr3", addr_q[3], 1);
    end
    check_words("wrap", '{100, -200, 5, -3});

    run(10, 8, 0, 0, 1, 1);
    check_words("stall", '{11, -12, 13, -14, 15, -16, 17, -18});
    check("stall_stable", stab_err, 0);
    check("stall_addr_n", addr_q.size(), 8);

    run(30, 3, 0, 1, 0, 1);
    check_words("clr", '{1, 2, 3});
    check("clr_n", clear_cnt, 1);
    check("clr_cyc", clear_cyc, last_pop + 2);
    check("clr_done", done_cyc, clear_cyc + 1);
    check("clr_overlap", overlap, 0);

    run(5, 0, 0, 0, 0, 0);
    check("zero_done_cyc", done_cyc, 0);
    check("zero_done_n", done_cnt, 1);
    check("zero_reads", addr_q.size(), 0);
    check("zero_valid", valid_cnt, 0);
    check("zero_busy_after", busy_after, 0);

    // reset in the middle of a drain that asked for a clear
    @(negedge clk);
    start = 1; base_addr = AW'(20); num_rows = (AW+1)'(6); relu_en = 0; clear_after = 1;
    @(negedge clk);
    start = 0;
    pops = 0;
    for (int i = 0; i < 50 && pops < 2; i++) begin
      out_ready = 1;
      #1;
      if (out_valid && out_ready) pops++;
      if (pops < 2) @(negedge clk);
    end
    check("mid_pops", pops, 2);
    #2 rst_n = 0;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_valid", int'(out_valid), 0);
    check("mid_data", int'(out_data), 0);
    check("mid_last", int'(out_last), 0);
    check("mid_rd_en", int'(acc_rd_en), 0);
    check("mid_addr", int'(acc_rd_address), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (acc_clear || out_valid || busy || done) bad++;
      @(negedge clk);
    end
    check("mid_quiet", bad, 0);
    run(20, 6, 0, 0, 0, 1);
    check_words("after_rst", '{21, -22, 23, 24, -25, 26});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
